// File: rtl/fir_ctrl_ntap.sv
// N-tap FIR datapath sequencer: coefficient loading and per-sample convolution,
// issuing one micro-op per cycle to the shared ALU/register-file datapath.
module fir_ctrl_ntap #(
  parameter int         NUM_TAPS = 4,
  parameter logic [5:0] SUB_MASK = 6'b000000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dr,
  input  logic       lc,
  input  logic       overflow,
  output logic       cnt_up,
  output logic       clear,
  output logic       modwait,
  output logic [2:0] op,
  output logic [3:0] src1,
  output logic [3:0] src2,
  output logic [3:0] dest,
  output logic       err
);

  // state       | meaning
  // IDLE        | waiting for dr / lc
  // EIDLE       | error hold (dr glitch or overflow), err=1
  // COEF_LOAD   | load coefficient k into R(N+1+k)
  // COEF_WAIT   | wait for next lc
  // SAMPLE_LOAD | load incoming sample into R(2N+2)
  // CLEAR_ACC   | R0 = R0 - R0, count the sample
  // SHIFT       | R(k+1) = R(k), k counts down to 1
  // LOAD_S1     | R1 = newest sample
  // MUL         | temp = R(k+1) * F(k)
  // ACC         | R0 = R0 +/- temp
  typedef enum logic [3:0] {
    IDLE, EIDLE, COEF_LOAD, COEF_WAIT, SAMPLE_LOAD,
    CLEAR_ACC, SHIFT, LOAD_S1, MUL, ACC
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_COPY = 3'b001;
  localparam logic [2:0] OP_LDS  = 3'b010;
  localparam logic [2:0] OP_LDC  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  localparam logic [3:0] NUM_R     = 4'(NUM_TAPS);
  localparam logic [3:0] COEF_BASE = 4'(NUM_TAPS + 1);
  localparam logic [3:0] TEMP_REG  = 4'(2 * NUM_TAPS + 1);
  localparam logic [3:0] SAMP_REG  = 4'(2 * NUM_TAPS + 2);
  localparam logic [2:0] LAST_K    = 3'(NUM_TAPS - 1);
  localparam logic [7:0] SUB_EXT   = {2'b00, SUB_MASK};

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic       modwait_q, modwait_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      k_q       <= 3'd0;
      modwait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      modwait_q <= modwait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE, EIDLE: begin
        if (dr) begin
          state_d = SAMPLE_LOAD;
        end else if (lc) begin
          state_d = COEF_LOAD;
          k_d     = 3'd0;
        end
      end
      COEF_LOAD: begin
        if (k_q == LAST_K) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          state_d = COEF_WAIT;
          k_d     = k_q + 3'd1;
        end
      end
      COEF_WAIT: if (lc) state_d = COEF_LOAD;
      SAMPLE_LOAD: state_d = dr ? CLEAR_ACC : EIDLE;
      CLEAR_ACC: begin
        k_d     = LAST_K;
        state_d = (LAST_K == 3'd0) ? LOAD_S1 : SHIFT;
      end
      SHIFT: begin
        if (k_q == 3'd1) state_d = LOAD_S1;
        else             k_d     = k_q - 3'd1;
      end
      LOAD_S1: begin
        state_d = MUL;
        k_d     = 3'd0;
      end
      MUL: state_d = ACC;
      ACC: begin
        if (k_q == LAST_K) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          state_d = MUL;
          k_d     = k_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = 3'd0;
      end
    endcase

    // Overflow only matters once the accumulator is in use.
    if (overflow && (state_q == CLEAR_ACC || state_q == SHIFT || state_q == LOAD_S1 ||
                     state_q == MUL || state_q == ACC)) begin
      state_d = EIDLE;
      k_d     = 3'd0;
    end

    modwait_d = (state_d == COEF_LOAD) || (state_d == SAMPLE_LOAD) || (state_d == CLEAR_ACC) ||
                (state_d == SHIFT) || (state_d == LOAD_S1) || (state_d == MUL) || (state_d == ACC);
  end

  always_comb begin
    op     = OP_NOP;
    src1   = 4'd0;
    src2   = 4'd0;
    dest   = 4'd0;
    cnt_up = 1'b0;
    clear  = 1'b0;
    err    = 1'b0;
    case (state_q)
      EIDLE: err = 1'b1;
      COEF_LOAD: begin
        op    = OP_LDC;
        dest  = COEF_BASE + {1'b0, k_q};
        clear = 1'b1;
      end
      COEF_WAIT: begin
        // k already advanced; keep pointing at the coefficient just loaded
        dest  = NUM_R + {1'b0, k_q};
        clear = 1'b1;
      end
      SAMPLE_LOAD: begin
        op   = OP_LDS;
        dest = SAMP_REG;
      end
      CLEAR_ACC: begin
        op     = OP_SUB;
        cnt_up = 1'b1;
      end
      SHIFT: begin
        op   = OP_COPY;
        src1 = {1'b0, k_q};
        dest = {1'b0, k_q} + 4'd1;
      end
      LOAD_S1: begin
        op   = OP_COPY;
        src1 = SAMP_REG;
        dest = 4'd1;
      end
      MUL: begin
        op   = OP_MUL;
        src1 = {1'b0, k_q} + 4'd1;
        src2 = COEF_BASE + {1'b0, k_q};
        dest = TEMP_REG;
      end
      ACC: begin
        op   = SUB_EXT[k_q] ? OP_SUB : OP_ADD;
        src2 = TEMP_REG;
      end
      default: ;
    endcase
  end

  assign modwait = modwait_q;

endmodule

// File: tb/tb_fir_ctrl_ntap.sv
// Table-driven bench for fir_ctrl_ntap: four instances (N=4, N=4 with a sub mask,
// N=2, N=1) share stimulus; each vector checks one selected instance.
module tb_fir_ctrl_ntap;

  logic clk = 1'b0;
  logic n_rst, dr, lc, overflow;

  logic [2:0] op_o   [4];
  logic [3:0] s1_o   [4];
  logic [3:0] s2_o   [4];
  logic [3:0] d_o    [4];
  logic       mw_o   [4];
  logic       cu_o   [4];
  logic       clr_o  [4];
  logic       err_o  [4];
  logic [18:0] out_w [4];

  always #5 clk = ~clk;

  fir_ctrl_ntap #(.NUM_TAPS(4), .SUB_MASK(6'b000000)) u_n4 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cu_o[0]), .clear(clr_o[0]), .modwait(mw_o[0]), .op(op_o[0]),
    .src1(s1_o[0]), .src2(s2_o[0]), .dest(d_o[0]), .err(err_o[0]));
  fir_ctrl_ntap #(.NUM_TAPS(4), .SUB_MASK(6'b001010)) u_n4m (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cu_o[1]), .clear(clr_o[1]), .modwait(mw_o[1]), .op(op_o[1]),
    .src1(s1_o[1]), .src2(s2_o[1]), .dest(d_o[1]), .err(err_o[1]));
  fir_ctrl_ntap #(.NUM_TAPS(2), .SUB_MASK(6'b000000)) u_n2 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cu_o[2]), .clear(clr_o[2]), .modwait(mw_o[2]), .op(op_o[2]),
    .src1(s1_o[2]), .src2(s2_o[2]), .dest(d_o[2]), .err(err_o[2]));
  fir_ctrl_ntap #(.NUM_TAPS(1), .SUB_MASK(6'b000000)) u_n1 (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .cnt_up(cu_o[3]), .clear(clr_o[3]), .modwait(mw_o[3]), .op(op_o[3]),
    .src1(s1_o[3]), .src2(s2_o[3]), .dest(d_o[3]), .err(err_o[3]));

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign out_w[g] = {op_o[g], s1_o[g], s2_o[g], d_o[g], mw_o[g], cu_o[g], clr_o[g], err_o[g]};
  end

  typedef struct {
    int          inst;
    bit          rst;
    bit          dr;
    bit          lc;
    bit          ovf;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [18:0] pk(input int op, input int s1, input int s2, input int d,
                                     input bit mw, input bit cu, input bit clr, input bit er);
    return {3'(op), 4'(s1), 4'(s2), 4'(d), mw, cu, clr, er};
  endfunction

  function automatic void add(input int inst, input bit rst, input bit d, input bit l,
                              input bit o, input logic [18:0] e);
    vec_t t;
    t.inst = inst; t.rst = rst; t.dr = d; t.lc = l; t.ovf = o; t.exp = e;
    vq.push_back(t);
  endfunction

  // Full sample sequence for an N-tap instance, expectations built from the register map.
  function automatic void push_sample(input int inst, input int n, input int mask,
                                      input bit do_rst, input bit both);
    if (do_rst) add(inst, 1'b1, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(inst, 1'b0, 1'b1, both, 1'b0, pk(2, 0, 0, 2*n+2, 1, 0, 0, 0));
    add(inst, 1'b0, 1'b1, 1'b0, 1'b0, pk(5, 0, 0, 0, 1, 1, 0, 0));
    for (int k = n - 1; k >= 1; k--)
      add(inst, 1'b0, 1'b0, 1'b0, 1'b0, pk(1, k, 0, k+1, 1, 0, 0, 0));
    add(inst, 1'b0, 1'b0, 1'b0, 1'b0, pk(1, 2*n+2, 0, 1, 1, 0, 0, 0));
    for (int k = 0; k < n; k++) begin
      add(inst, 1'b0, 1'b0, 1'b0, 1'b0, pk(6, k+1, n+1+k, 2*n+1, 1, 0, 0, 0));
      add(inst, 1'b0, 1'b0, 1'b0, 1'b0, pk(((mask >> k) & 1) != 0 ? 5 : 4, 0, 2*n+1, 0, 1, 0, 0, 0));
    end
    add(inst, 1'b0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 0, 0));
  endfunction

  int busy [4];
  int pulses [4];
  int exp_busy [4] = '{14, 14, 8, 5};

  initial begin
    n_rst = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0;

    // Coefficient load, N=4: dests 5..8, dr ignored while waiting for lc.
    add(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, 0, pk(3, 0, 0, 5, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 5, 0, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 5, 0, 0, 1, 0));
    add(0, 0, 0, 1, 0, pk(3, 0, 0, 6, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 6, 0, 0, 1, 0));
    add(0, 0, 1, 0, 0, pk(0, 0, 0, 6, 0, 0, 1, 0));
    add(0, 0, 0, 1, 0, pk(3, 0, 0, 7, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 7, 0, 0, 1, 0));
    add(0, 0, 0, 1, 0, pk(3, 0, 0, 8, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));

    push_sample(0, 4, 0,  1'b1, 1'b0);
    push_sample(1, 4, 10, 1'b1, 1'b0);
    push_sample(2, 2, 0,  1'b1, 1'b0);
    push_sample(3, 1, 0,  1'b1, 1'b1);
    push_sample(0, 4, 0,  1'b1, 1'b1);

    // dr glitch -> EIDLE, then recovery by a held dr.
    add(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(2, 0, 0, 10, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 1));
    push_sample(0, 4, 0, 1'b0, 1'b0);

    // Overflow: ignored in SAMPLE_LOAD and EIDLE, aborts in MUL(1); lc recovers.
    add(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(2, 0, 0, 10, 1, 0, 0, 0));
    add(0, 0, 1, 0, 1, pk(5, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 3, 0, 4, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 2, 0, 3, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 1, 0, 2, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 10, 0, 1, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(6, 1, 5, 9, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(4, 0, 9, 0, 1, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(6, 2, 6, 9, 1, 0, 0, 0));
    add(0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 0, 0, 1));
    add(0, 0, 0, 1, 0, pk(3, 0, 0, 5, 1, 0, 1, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 5, 0, 0, 1, 0));

    // Reset asserted mid-SHIFT, then a clean restart.
    add(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(2, 0, 0, 10, 1, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(5, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 3, 0, 4, 1, 0, 0, 0));
    add(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(2, 0, 0, 10, 1, 0, 0, 0));
    add(0, 0, 1, 0, 0, pk(5, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, 0, pk(1, 3, 0, 4, 1, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    foreach (vq[i]) begin
      n_rst    = !vq[i].rst;
      dr       = vq[i].dr;
      lc       = vq[i].lc;
      overflow = vq[i].ovf;
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_w[vq[i].inst] !== vq[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d inst%0d: got op=%0d s1=%0d s2=%0d d=%0d mw/cu/clr/err=%b, want op=%0d s1=%0d s2=%0d d=%0d mw/cu/clr/err=%b",
                 i, vq[i].inst,
                 out_w[vq[i].inst][18:16], out_w[vq[i].inst][15:12], out_w[vq[i].inst][11:8],
                 out_w[vq[i].inst][7:4], out_w[vq[i].inst][3:0],
                 vq[i].exp[18:16], vq[i].exp[15:12], vq[i].exp[11:8], vq[i].exp[7:4], vq[i].exp[3:0]);
      end
    end

    // Busy-cycle and cnt_up counts per instance for one sample, dr held 2 cycles.
    n_rst = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    dr    = 1'b1;
    for (int i = 0; i < 4; i++) begin busy[i] = 0; pulses[i] = 0; end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) dr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (mw_o[i]) busy[i]++;
        if (cu_o[i]) pulses[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (busy[i] != exp_busy[i]) begin
        n_bad++;
        $display("FAIL busy_cycles inst%0d: got %0d, want %0d", i, busy[i], exp_busy[i]);
      end
      n_cmp++;
      if (pulses[i] != 1) begin
        n_bad++;
        $display("FAIL cnt_up_pulses inst%0d: got %0d, want 1", i, pulses[i]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
